pwm_duty_scheduler: RTL and testbench

//  Sequences duty-cycle updates for a pwm channel from accelerometer samples (spi_control data_x/data_update).

---
 rtl/pwm_sched_if.sv | 27 ++
 rtl/pwm_duty_scheduler.sv | 168 ++++++++++++++++
 tb/tb_pwm_duty_scheduler.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/pwm_sched_if.sv
// Sample/commit bus between the spi_control front end, the duty scheduler and the pwm channel.
interface pwm_sched_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DUTY_W = 8
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample;
  logic                     period_end;
  logic                     hold;
  logic [DUTY_W-1:0]        duty;
  logic [DUTY_W-1:0]        target;
  logic                     busy;
  logic                     apply_strobe;
  logic                     at_max;
  logic                     at_min;
  logic [7:0]               drop_cnt;

  modport master (
    output sample_valid, sample, period_end, hold,
    input  duty, target, busy, apply_strobe, at_max, at_min, drop_cnt
  );

  modport slave (
    input  sample_valid, sample, period_end, hold,
    output duty, target, busy, apply_strobe, at_max, at_min, drop_cnt
  );
endinterface

// File: rtl/pwm_duty_scheduler.sv
// Steps a PWM duty target from accelerometer samples and commits it only at PWM period boundaries.
// Optional macro PWM_SCHED_DEADBAND_EN: step only when |delta| > DEADBAND, prev tracks stepped samples only.
module pwm_duty_scheduler #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DUTY_W    = 8,
  parameter int unsigned STEP      = 5,
  parameter int unsigned MAX_DUTY  = 100,
  parameter int unsigned INIT_DUTY = 50,
  parameter int unsigned DEADBAND  = 32
) (
  input  logic         clk,
  input  logic         reset,
  pwm_sched_if.slave   bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] PEND = 2'd2;

  localparam logic [DUTY_W-1:0] MAX_D  = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(STEP);
  localparam logic [DUTY_W-1:0] INIT_D = DUTY_W'(INIT_DUTY);
  localparam logic [DATA_W:0]   DB_D   = (DATA_W+1)'(DEADBAND);

`ifdef PWM_SCHED_DEADBAND_EN
  localparam bit DEADBAND_EN = 1'b1;
`else
  localparam bit DEADBAND_EN = 1'b0;
`endif

  logic [1:0]               state_q, state_d;
  logic signed [DATA_W-1:0] cur_q, cur_d;
  logic signed [DATA_W-1:0] prev_q, prev_d;
  logic signed [DATA_W-1:0] pend_q, pend_d;
  logic                     primed_q, primed_d;
  logic                     pend_v_q, pend_v_d;
  logic [DUTY_W-1:0]        duty_q, duty_d;
  logic [DUTY_W-1:0]        target_q, target_d;
  logic [7:0]               drop_q, drop_d;
  logic                     strobe_q, strobe_d;
  logic                     busy_q, busy_d;
  logic                     at_max_q, at_max_d;
  logic                     at_min_q, at_min_d;

  logic signed [DATA_W:0]   delta;
  logic [DATA_W:0]          abs_delta;
  logic                     step_en;
  logic                     drop_inc;
  logic                     take_new;
  logic                     take_pend;
  logic [DUTY_W-1:0]        target_up;
  logic [DUTY_W-1:0]        target_dn;
  logic [DUTY_W-1:0]        target_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      prev_q   <= '0;
      pend_q   <= '0;
      primed_q <= 1'b0;
      pend_v_q <= 1'b0;
      duty_q   <= INIT_D;
      target_q <= INIT_D;
      drop_q   <= '0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
      at_max_q <= (INIT_D == MAX_D);
      at_min_q <= (INIT_D == '0);
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      prev_q   <= prev_d;
      pend_q   <= pend_d;
      primed_q <= primed_d;
      pend_v_q <= pend_v_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      drop_q   <= drop_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    prev_d   = prev_q;
    pend_d   = pend_q;
    primed_d = primed_q;
    pend_v_d = pend_v_q;
    duty_d   = duty_q;
    target_d = target_q;
    strobe_d = 1'b0;
    drop_inc = 1'b0;

    // One extra sign bit keeps the difference exact for any pair of samples.
    delta     = $signed({cur_q[DATA_W-1], cur_q}) - $signed({prev_q[DATA_W-1], prev_q});
    abs_delta = delta[DATA_W] ? $unsigned(-delta) : $unsigned(delta);
    step_en   = (delta != '0) && (!DEADBAND_EN || (abs_delta > DB_D));
    target_up = (target_q > (MAX_D - STEP_D)) ? MAX_D : target_q + STEP_D;
    target_dn = (target_q < STEP_D) ? '0 : target_q - STEP_D;
    target_nx = delta[DATA_W] ? target_dn : target_up;

    take_new  = (state_q == IDLE) && !bus.hold && bus.sample_valid;
    take_pend = (state_q == IDLE) && !bus.hold && !bus.sample_valid && pend_v_q;

    // 1-deep latest-wins slot for samples that cannot be evaluated right away.
    if (bus.sample_valid && ((state_q != IDLE) || bus.hold)) begin
      pend_d   = bus.sample;
      pend_v_d = 1'b1;
      drop_inc = pend_v_q;
    end

    if (take_new) begin
      cur_d    = bus.sample;
      pend_v_d = 1'b0;
      drop_inc = pend_v_q;
      state_d  = EVAL;
    end else if (take_pend) begin
      cur_d    = pend_q;
      pend_v_d = 1'b0;
      state_d  = EVAL;
    end

    case (state_q)
      IDLE: ;
      EVAL: begin
        state_d = IDLE;
        if (!primed_q) begin
          prev_d   = cur_q;
          primed_d = 1'b1;
        end else begin
          if (!DEADBAND_EN) prev_d = cur_q;
          if (step_en) begin
            prev_d   = cur_q;
            target_d = target_nx;
            if (target_nx != duty_q) state_d = PEND;
          end
        end
      end
      PEND: begin
        if (bus.period_end) begin
          duty_d   = target_q;
          strobe_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    drop_d   = (drop_inc && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
    busy_d   = (state_d != IDLE);
    at_max_d = (duty_d == MAX_D);
    at_min_d = (duty_d == '0);
  end

  assign bus.duty         = duty_q;
  assign bus.target       = target_q;
  assign bus.busy         = busy_q;
  assign bus.apply_strobe = strobe_q;
  assign bus.at_max       = at_max_q;
  assign bus.at_min       = at_min_q;
  assign bus.drop_cnt     = drop_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed self-checking bench for pwm_duty_scheduler; follows PWM_SCHED_DEADBAND_EN when defined.
module tb_pwm_duty_scheduler;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned DUTY_W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   v;

  pwm_sched_if #(.DATA_W(DATA_W), .DUTY_W(DUTY_W)) bus ();

  pwm_duty_scheduler #(
    .DATA_W(DATA_W), .DUTY_W(DUTY_W), .STEP(5), .MAX_DUTY(100),
    .INIT_DUTY(50), .DEADBAND(32)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s);
    bus.sample_valid = 1'b1;
    bus.sample       = 16'(s);
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic commit();
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample       = '0;
    bus.period_end   = 1'b0;
    bus.hold         = 1'b0;
    #12;
    check("rst_duty",   32'(bus.duty), 32'd50);
    check("rst_target", 32'(bus.target), 32'd50);
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_strobe", 32'(bus.apply_strobe), 32'd0);
    check("rst_at_max", 32'(bus.at_max), 32'd0);
    check("rst_at_min", 32'(bus.at_min), 32'd0);
    check("rst_drop",   32'(bus.drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // first sample primes, second steps up
    send(0);
    check("t1_prime_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_prime_idle", 32'(bus.busy), 32'd0);
    check("t1_prime_target", 32'(bus.target), 32'd50);
    send(100);
    tick();
    check("t1_target", 32'(bus.target), 32'd55);
    check("t1_duty_held", 32'(bus.duty), 32'd50);
    check("t1_pend_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_duty_wait", 32'(bus.duty), 32'd50);
    commit();
    check("t1_duty", 32'(bus.duty), 32'd55);
    check("t1_strobe", 32'(bus.apply_strobe), 32'd1);
    check("t1_idle", 32'(bus.busy), 32'd0);
    tick();
    check("t1_strobe_off", 32'(bus.apply_strobe), 32'd0);

    // climb to the upper clamp, then one more rise
    v = 100;
    for (int i = 0; i < 9; i++) begin
      v += 100;
      send(v);
      tick();
      commit();
    end
    check("t2_duty_max", 32'(bus.duty), 32'd100);
    check("t2_at_max", 32'(bus.at_max), 32'd1);
    v += 100;
    send(v);
    tick();
    check("t2_max_no_pend", 32'(bus.busy), 32'd0);
    check("t2_max_target", 32'(bus.target), 32'd100);
    commit();
    check("t2_max_no_strobe", 32'(bus.apply_strobe), 32'd0);
    check("t2_max_duty", 32'(bus.duty), 32'd100);

    // descend to the lower clamp, then one more fall
    for (int i = 0; i < 20; i++) begin
      v -= 100;
      send(v);
      tick();
      commit();
    end
    check("t2_duty_min", 32'(bus.duty), 32'd0);
    check("t2_at_min", 32'(bus.at_min), 32'd1);
    check("t2_at_max_off", 32'(bus.at_max), 32'd0);
    v -= 100;
    send(v);
    tick();
    check("t2_min_no_pend", 32'(bus.busy), 32'd0);
    check("t2_min_target", 32'(bus.target), 32'd0);

    // two samples during PEND: latest wins, one drop
    send(0);
    tick();
    check("t3_target", 32'(bus.target), 32'd5);
    send(10);
    send(-50);
    check("t3_drop", 32'(bus.drop_cnt), 32'd1);
    check("t3_busy", 32'(bus.busy), 32'd1);
    check("t3_duty_held", 32'(bus.duty), 32'd0);
    commit();
    check("t3_duty", 32'(bus.duty), 32'd5);
    check("t3_strobe", 32'(bus.apply_strobe), 32'd1);
    tick();
    check("t3_slot_eval", 32'(bus.busy), 32'd1);
    tick();
    check("t3_latest_target", 32'(bus.target), 32'd0);
    check("t3_latest_pend", 32'(bus.busy), 32'd1);
    commit();
    check("t3_latest_duty", 32'(bus.duty), 32'd0);

    // hold blocks evaluation; three samples collapse to the last one
    bus.hold = 1'b1;
    send(100);
    send(200);
    send(-300);
    check("t4_hold_idle", 32'(bus.busy), 32'd0);
    check("t4_drop", 32'(bus.drop_cnt), 32'd3);
    bus.hold = 1'b0;
    tick();
    check("t4_eval", 32'(bus.busy), 32'd1);
    tick();
    check("t4_no_pend", 32'(bus.busy), 32'd0);
    check("t4_target", 32'(bus.target), 32'd0);
    tick();
    check("t4_single_eval", 32'(bus.busy), 32'd0);

    // period_end on entry into PEND is ignored
    send(0);
    bus.period_end = 1'b1;
    tick();
    bus.period_end = 1'b0;
    check("t5_pend", 32'(bus.busy), 32'd1);
    check("t5_target", 32'(bus.target), 32'd5);
    check("t5_no_strobe", 32'(bus.apply_strobe), 32'd0);
    check("t5_duty_held", 32'(bus.duty), 32'd0);
    tick();
    check("t5_still_pend", 32'(bus.busy), 32'd1);
    commit();
    check("t5_duty", 32'(bus.duty), 32'd5);
    check("t5_strobe", 32'(bus.apply_strobe), 32'd1);

    // asynchronous reset in the middle of PEND
    send(100);
    tick();
    check("t5_pend2_target", 32'(bus.target), 32'd10);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_duty", 32'(bus.duty), 32'd50);
    check("t5_rst_target", 32'(bus.target), 32'd50);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_drop", 32'(bus.drop_cnt), 32'd0);
    #2 rst = 1'b0;
    tick();

    // small then larger rise from a primed 0
    send(0);
    tick();
    check("t6_prime_target", 32'(bus.target), 32'd50);
    send(20);
    tick();
`ifdef PWM_SCHED_DEADBAND_EN
    check("t6_small_target", 32'(bus.target), 32'd50);
    check("t6_small_busy", 32'(bus.busy), 32'd0);
`else
    check("t6_small_target", 32'(bus.target), 32'd55);
    check("t6_small_busy", 32'(bus.busy), 32'd1);
`endif
    commit();
    send(40);
    tick();
`ifdef PWM_SCHED_DEADBAND_EN
    check("t6_big_target", 32'(bus.target), 32'd55);
`else
    check("t6_big_target", 32'(bus.target), 32'd60);
`endif
    commit();
`ifdef PWM_SCHED_DEADBAND_EN
    check("t6_duty", 32'(bus.duty), 32'd55);
`else
    check("t6_duty", 32'(bus.duty), 32'd60);
`endif

    // drop counter saturates
    bus.hold = 1'b1;
    for (int i = 0; i < 260; i++) send(i);
    check("t7_drop_sat", 32'(bus.drop_cnt), 32'd255);
    bus.hold = 1'b0;
    tick();
    tick();
    check("t7_drop_kept", 32'(bus.drop_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
